tarhi_io_slave: RTL and testbench

//  Memory-mapped I/O responder on the tarhi CPU memory bus (mem_enable/mem_write/mem_addr/data).

---
 rtl/tarhi_io_slave_if.sv | 28 ++
 rtl/tarhi_io_slave.sv | 96 +++++++++
 tb/tb_tarhi_io_slave.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tarhi_io_slave_if.sv
// tarhi CPU memory bus, target side of one access per cycle.
// Carries request strobes, addresses, data and the read-hit flag.
interface tarhi_io_slave_if;
  logic        mem_enable;
  logic        mem_write;
  logic [23:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        rd_hit;

  modport master (
    output mem_enable,
    output mem_write,
    output mem_addr,
    output mem_din,
    input  mem_dout,
    input  rd_hit
  );

  modport slave (
    input  mem_enable,
    input  mem_write,
    input  mem_addr,
    input  mem_din,
    output mem_dout,
    output rd_hit
  );
endinterface

// File: rtl/tarhi_io_slave.sv
// tarhi memory-mapped I/O responder: LED register, 32-bit timer
// with compare, sticky match flag and interrupt.
module tarhi_io_slave #(
  parameter logic [23:0] BASE_ADDR = 24'hFFFF00,
  parameter int          LED_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  tarhi_io_slave_if.slave      bus,
  output logic [LED_WIDTH-1:0] ledg,
  output logic                 irq
);

  logic [LED_WIDTH-1:0] led;
  logic [2:0]           ctrl;
  logic [31:0]          count;
  logic [31:0]          compare;
  logic                 status;

  logic                 hit;
  logic                 wr;
  logic                 rd;
  logic [3:0]           off;
  logic                 match;
  logic                 st_clr;
  logic                 status_n;
  logic [2:0]           ctrl_n;
  logic [31:0]          count_n;
  logic [31:0]          rdata;

  assign hit = bus.mem_enable &&
               (bus.mem_addr[23:4] == BASE_ADDR[23:4]);
  assign off = bus.mem_addr[3:0];
  assign wr  = hit & bus.mem_write;
  assign rd  = hit & ~bus.mem_write;

  assign match = ctrl[0] && (count == compare);

  // A flag raised in the same cycle as a clear survives.
  assign st_clr = (rd && off == 4'd4) ||
                  (wr && off == 4'd4 && bus.mem_din[0]);
  assign status_n = match | (status & ~st_clr);

  assign ctrl_n = (wr && off == 4'd1) ?
                  bus.mem_din[2:0] : ctrl;

  always_comb begin
    count_n = count;
    if (wr && off == 4'd2)
      count_n = bus.mem_din;
    else if (match && ctrl[1])
      count_n = '0;
    else if (ctrl[0])
      count_n = count + 32'd1;
  end

  always_comb begin
    rdata = '0;
    case (off)
      4'd0:    rdata = 32'(led);
      4'd1:    rdata = {29'd0, ctrl};
      4'd2:    rdata = count;
      4'd3:    rdata = compare;
      4'd4:    rdata = {31'd0, status};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led          <= '0;
      ctrl         <= '0;
      count        <= '0;
      compare      <= '1;
      status       <= 1'b0;
      bus.mem_dout <= '0;
      bus.rd_hit   <= 1'b0;
      irq          <= 1'b0;
    end else begin
      if (wr && off == 4'd0)
        led <= bus.mem_din[LED_WIDTH-1:0];
      if (wr && off == 4'd3)
        compare <= bus.mem_din;
      ctrl       <= ctrl_n;
      count      <= count_n;
      status     <= status_n;
      irq        <= status_n & ctrl_n[2];
      bus.rd_hit <= rd;
      if (rd)
        bus.mem_dout <= rdata;
    end
  end

  assign ledg = led;

endmodule

// File: tb/tb_tarhi_io_slave.sv
// Directed bench for tarhi_io_slave: reset, LED, window decode,
// timer/match/irq, write-1-to-clear, wrap and back-to-back access.
module tb_tarhi_io_slave;
  localparam logic [23:0] B = 24'hFFFF00;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] ledg;
  logic       irq;
  int         checks = 0;
  int         failures = 0;

  tarhi_io_slave_if bus();

  tarhi_io_slave #(.BASE_ADDR(B), .LED_WIDTH(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .ledg  (ledg),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [23:0] a, input logic [31:0] d);
    bus.mem_enable = 1'b1;
    bus.mem_write  = 1'b1;
    bus.mem_addr   = a;
    bus.mem_din    = d;
    @(posedge clk);
    #1;
    bus.mem_enable = 1'b0;
    bus.mem_write  = 1'b0;
  endtask

  task automatic rd(input logic [23:0] a,
                    output logic [31:0] d, output logic h);
    bus.mem_enable = 1'b1;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = a;
    @(posedge clk);
    #1;
    d = bus.mem_dout;
    h = bus.rd_hit;
    bus.mem_enable = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        h;
    logic [31:0] exp [5];
    exp = '{32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0};
    reset = 1'b1;
    bus.mem_enable = 1'b1;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = B + 24'd3;
    idle(2);
    checks++;
    if (bus.rd_hit !== 1'b0 || bus.mem_dout !== 32'h0) begin
      failures++;
      $display("FAIL reset_bus got hit=%b dout=%h exp 0/0",
               bus.rd_hit, bus.mem_dout);
    end
    checks++;
    if (ledg !== 10'h0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_out got ledg=%h irq=%b exp 0/0",
               ledg, irq);
    end
    reset = 1'b0;
    bus.mem_enable = 1'b0;
    idle(1);
    checks++;
    if (bus.rd_hit !== 1'b0) begin
      failures++;
      $display("FAIL reset_discard got hit=%b exp 0", bus.rd_hit);
    end
    for (int i = 0; i < 5; i++) begin
      rd(B + 24'(i), d, h);
      checks++;
      if (d !== exp[i] || h !== 1'b1) begin
        failures++;
        $display("FAIL reset_read off=%0d got %h/%b exp %h/1",
                 i, d, h, exp[i]);
      end
    end
    idle(1);
    checks++;
    if (bus.rd_hit !== 1'b0) begin
      failures++;
      $display("FAIL rd_hit_pulse got %b exp 0", bus.rd_hit);
    end
  endtask

  task automatic test_led();
    logic [31:0] d;
    logic        h;
    wr(B, 32'h3FF5);
    checks++;
    if (ledg !== 10'h3F5) begin
      failures++;
      $display("FAIL led_write got %h exp 3f5", ledg);
    end
    rd(B, d, h);
    checks++;
    if (d !== 32'h3F5 || h !== 1'b1) begin
      failures++;
      $display("FAIL led_read got %h/%b exp 3f5/1", d, h);
    end
    idle(1);
    checks++;
    if (bus.mem_dout !== 32'h3F5 || bus.rd_hit !== 1'b0) begin
      failures++;
      $display("FAIL dout_hold got %h/%b exp 3f5/0",
               bus.mem_dout, bus.rd_hit);
    end
  endtask

  task automatic test_window();
    logic [31:0] d;
    logic        h;
    wr(B + 24'd8, 32'h123);
    rd(B + 24'd8, d, h);
    checks++;
    if (d !== 32'h0 || h !== 1'b1) begin
      failures++;
      $display("FAIL off8_read got %h/%b exp 0/1", d, h);
    end
    wr(B + 24'd16, 32'h0);
    checks++;
    if (ledg !== 10'h3F5) begin
      failures++;
      $display("FAIL outside_write got ledg=%h exp 3f5", ledg);
    end
    rd(B + 24'd16, d, h);
    checks++;
    if (h !== 1'b0) begin
      failures++;
      $display("FAIL outside_read got hit=%b exp 0", h);
    end
  endtask

  task automatic test_timer();
    logic [31:0] d;
    logic        h;
    do_reset();
    wr(B + 24'd3, 32'd5);
    wr(B + 24'd2, 32'd0);
    wr(B + 24'd1, 32'd7);
    idle(5);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_early got %b exp 0", irq);
    end
    idle(1);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_match got %b exp 1", irq);
    end
    rd(B + 24'd2, d, h);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("FAIL auto_clr got %h exp 0", d);
    end
    idle(4);
    rd(B + 24'd4, d, h);
    checks++;
    if (d !== 32'd1) begin
      failures++;
      $display("FAIL status_setwin got %h exp 1", d);
    end
    rd(B + 24'd4, d, h);
    checks++;
    if (d !== 32'd1) begin
      failures++;
      $display("FAIL status_kept got %h exp 1", d);
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_clear got %b exp 0", irq);
    end
    rd(B + 24'd4, d, h);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("FAIL status_rc got %h exp 0", d);
    end
    rd(B + 24'd2, d, h);
    checks++;
    if (d !== 32'd2) begin
      failures++;
      $display("FAIL count_run got %h exp 2", d);
    end
  endtask

  task automatic test_w1c();
    logic [31:0] d;
    logic        h;
    do_reset();
    wr(B + 24'd3, 32'd0);
    wr(B + 24'd1, 32'd5);
    wr(B + 24'd4, 32'd0);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL w1c_zero got irq=%b exp 1", irq);
    end
    wr(B + 24'd4, 32'd1);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL w1c_one got irq=%b exp 0", irq);
    end
    rd(B + 24'd4, d, h);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("FAIL w1c_status got %h exp 0", d);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    logic        h;
    do_reset();
    wr(B + 24'd2, 32'hFFFFFFFF);
    wr(B + 24'd1, 32'd1);
    rd(B + 24'd2, d, h);
    checks++;
    if (d !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL wrap_pre got %h exp ffffffff", d);
    end
    rd(B + 24'd2, d, h);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL wrap got %h exp 0", d);
    end
    wr(B + 24'd2, 32'd100);
    idle(2);
    rd(B + 24'd2, d, h);
    checks++;
    if (d !== 32'd102) begin
      failures++;
      $display("FAIL count_write got %0d exp 102", d);
    end
    rd(B + 24'd4, d, h);
    checks++;
    if (d !== 32'd1) begin
      failures++;
      $display("FAIL wrap_match got %h exp 1", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic        h;
    wr(B, 32'h2A);
    rd(B, d, h);
    checks++;
    if (d !== 32'h2A || h !== 1'b1) begin
      failures++;
      $display("FAIL b2b_led got %h/%b exp 2a/1", d, h);
    end
    rd(B + 24'd1, d, h);
    checks++;
    if (d !== 32'd1 || h !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ctrl got %h/%b exp 1/1", d, h);
    end
    wr(B + 24'd5, 32'hDEAD);
    rd(B + 24'd5, d, h);
    checks++;
    if (d !== 32'h0 || h !== 1'b1) begin
      failures++;
      $display("FAIL b2b_unused got %h/%b exp 0/1", d, h);
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.mem_enable = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_din    = '0;
    #1;
    test_reset();
    test_led();
    test_window();
    test_timer();
    test_w1c();
    test_wrap();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
